// File: rtl/spi_xfer_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// Opcodes cover the common serial-flash commands issued through it.
package spi_xfer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_PP        = 8'h02;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_SE        = 8'h20;

    localparam logic [7:0] FILL_BYTE    = 8'hFF;

    function automatic logic [2:0] clamp_addr_n(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/spi_xfer_seq.sv
// Sequences one framed SPI transaction (opcode, address, dummy, data) into spi_master.
// Latency: next byte offered on the edge after m_get; read bytes appear one cycle after m_put.
// Backpressure: tx paced by m_get, write data by wr_valid/wr_ready; read stream has none.
module spi_xfer_seq
    import spi_xfer_seq_pkg::*;
#(
    parameter int LW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    op,
    input  logic [31:0]   addr,
    input  logic [2:0]    addr_n,
    input  logic [3:0]    dummy_n,
    input  logic [LW-1:0] len,
    input  logic          wr,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          underrun,
    output logic [7:0]    m_in,
    input  logic          m_get,
    output logic          m_empty,
    input  logic [7:0]    m_out,
    input  logic          m_put
);

    localparam int CW = LW + 5;

    state_t        state;
    logic [31:0]   addr_q;
    logic [2:0]    an_q;
    logic          wr_q;
    logic [CW-1:0] hdr_n;
    logic [CW-1:0] tx_total;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;

    logic          take;
    logic [CW-1:0] tx_next;
    logic          next_last;
    logic          next_data;
    logic          next_addr;
    logic [1:0]    addr_sel;
    logic [7:0]    addr_byte;

    // tx_next is the index of the byte to offer once the current one is taken
    assign take      = m_get && !m_empty;
    assign tx_next   = tx_cnt + CW'(1);
    assign next_last = (tx_next == tx_total);
    assign next_data = (tx_next >= hdr_n);
    assign next_addr = (tx_next <= CW'(an_q));
    assign addr_sel  = an_q[1:0] - tx_next[1:0];
    assign addr_byte = addr_q[{addr_sel, 3'b000} +: 8];

    assign wr_ready  = !reset && take && !next_last && next_data && wr_q && wr_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            an_q     <= '0;
            wr_q     <= 1'b0;
            hdr_n    <= '0;
            tx_total <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            m_in     <= 8'h00;
            m_empty  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;

            if (state != ST_IDLE && m_put) begin
                rx_cnt <= rx_cnt + CW'(1);
                if (!wr_q && rx_cnt >= hdr_n) begin
                    rd_data  <= m_out;
                    rd_valid <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q   <= addr;
                        an_q     <= clamp_addr_n(addr_n);
                        wr_q     <= wr;
                        hdr_n    <= CW'(1) + CW'(clamp_addr_n(addr_n)) + CW'(dummy_n);
                        tx_total <= CW'(1) + CW'(clamp_addr_n(addr_n)) + CW'(dummy_n) + CW'(len);
                        tx_cnt   <= '0;
                        rx_cnt   <= '0;
                        underrun <= 1'b0;
                        busy     <= 1'b1;
                        m_in     <= op;
                        m_empty  <= 1'b0;
                        state    <= ST_CMD;
                    end
                end

                // Wait for every byte on the wire to come back before ending the frame
                ST_DRAIN: begin
                    if (rx_cnt == tx_cnt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    if (take) begin
                        tx_cnt <= tx_next;
                        if (next_last) begin
                            m_empty <= 1'b1;
                            state   <= ST_DRAIN;
                        end else if (next_data) begin
                            if (!wr_q) begin
                                m_in  <= FILL_BYTE;
                                state <= ST_DATA;
                            end else if (wr_valid) begin
                                m_in  <= wr_data;
                                state <= ST_DATA;
                            end else begin
                                underrun <= 1'b1;
                                m_empty  <= 1'b1;
                                state    <= ST_DRAIN;
                            end
                        end else if (next_addr) begin
                            m_in  <= addr_byte;
                            state <= ST_ADDR;
                        end else begin
                            m_in  <= FILL_BYTE;
                            state <= ST_DUMMY;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: behavioural byte-level master/flash and host models,
// frames scored against byte lists built from the transaction parameters.
module tb_spi_xfer_seq;
    import spi_xfer_seq_pkg::*;

    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    op = 8'h00;
    logic [31:0]   addr = 32'h0;
    logic [2:0]    addr_n = 3'd0;
    logic [3:0]    dummy_n = 4'd0;
    logic [LW-1:0] len = '0;
    logic          wr = 1'b0;
    logic [7:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          underrun;
    logic [7:0]    m_in;
    logic          m_get;
    logic          m_empty;
    logic [7:0]    m_out;
    logic          m_put;

    always #5 clock = ~clock;

    spi_xfer_seq #(.LW(LW)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .addr(addr),
        .addr_n(addr_n), .dummy_n(dummy_n), .len(len), .wr(wr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .underrun(underrun), .m_in(m_in), .m_get(m_get), .m_empty(m_empty),
        .m_out(m_out), .m_put(m_put)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] sent_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] wr_bytes[$];
    logic [7:0] flash_bytes[$];
    int         pend_due[$];
    int         done_cnt = 0;
    int         done_busy_bad = 0;
    int         wr_rdy_cnt = 0;
    int         wr_idx = 0;
    int         wr_avail = 0;
    int         hdr_exp = 1;
    int         rx_idx = 0;
    int         cyc = 0;
    int         last_due = 0;
    bit         stray_put = 1'b0;

    logic [7:0]  cfg_op;
    logic [31:0] cfg_addr;
    int          cfg_an, cfg_dn, cfg_len, cfg_avail;
    bit          cfg_wr;

    // Master/flash/host model: drives on negedge, samples handshakes mid-low-phase
    initial begin
        int due;
        m_get = 1'b0; m_put = 1'b0; m_out = 8'h00; wr_valid = 1'b0; wr_data = 8'h00;
        forever begin
            @(negedge clock);
            cyc++;
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) begin
                done_cnt++;
                if (busy) done_busy_bad++;
            end
            if (reset) begin
                pend_due.delete();
                last_due = 0;
                rx_idx = 0;
                m_get = 1'b0; m_put = 1'b0; wr_valid = 1'b0;
            end else begin
                m_get = !m_empty && ($urandom_range(0, 3) != 0);
                m_put = 1'b0;
                if (stray_put) begin
                    m_put = 1'b1;
                    m_out = 8'($urandom);
                    stray_put = 1'b0;
                end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    void'(pend_due.pop_front());
                    m_put = 1'b1;
                    if (rx_idx >= hdr_exp && rx_idx - hdr_exp < flash_bytes.size())
                        m_out = flash_bytes[rx_idx - hdr_exp];
                    else
                        m_out = 8'($urandom);
                    rx_idx++;
                end
                wr_valid = (wr_idx < wr_avail);
                wr_data  = wr_valid ? wr_bytes[wr_idx] : 8'h00;
            end
            #2;
            if (m_get && !m_empty) begin
                sent_q.push_back(m_in);
                due = cyc + int'($urandom_range(1, 4));
                if (due <= last_due) due = last_due + 1;
                pend_due.push_back(due);
                last_due = due;
            end
            if (wr_ready) begin
                wr_idx++;
                wr_rdy_cnt++;
            end
        end
    end

    task automatic launch(input logic [7:0] o, input logic [31:0] a, input logic [2:0] an,
                          input logic [3:0] dn, input int ln, input bit w, input int av);
        @(negedge clock); #1;
        cfg_op = o; cfg_addr = a; cfg_an = (an > 3'd4) ? 4 : int'(an);
        cfg_dn = int'(dn); cfg_len = ln; cfg_wr = w;
        cfg_avail = w ? ((av < ln) ? av : ln) : 0;
        sent_q.delete(); rd_q.delete(); wr_bytes.delete(); flash_bytes.delete();
        done_cnt = 0; done_busy_bad = 0; wr_rdy_cnt = 0;
        for (int i = 0; i < ln; i++) begin
            wr_bytes.push_back(8'($urandom));
            flash_bytes.push_back(8'($urandom));
        end
        wr_idx = 0; wr_avail = cfg_avail;
        hdr_exp = 1 + cfg_an + cfg_dn; rx_idx = 0;
        op = o; addr = a; addr_n = an; dummy_n = dn; len = LW'(ln); wr = w;
        start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clock); #1;
            n++;
        end
        if (done_cnt == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: done never pulsed within %0d cycles", name, n);
        end
        repeat (4) @(negedge clock);
        #1;
    endtask

    // Frame scoreboard: expected wire bytes and read stream derived from the transaction
    task automatic scoreboard_frame(input string name);
        logic [7:0] exp_tx[$];
        logic [7:0] exp_rd[$];
        int n_data;
        bit exp_under;
        exp_tx.push_back(cfg_op);
        for (int k = 0; k < cfg_an; k++)
            exp_tx.push_back(8'((cfg_addr >> (8 * (cfg_an - 1 - k))) & 32'hFF));
        for (int k = 0; k < cfg_dn; k++) exp_tx.push_back(8'hFF);
        n_data = cfg_wr ? cfg_avail : cfg_len;
        for (int k = 0; k < n_data; k++) exp_tx.push_back(cfg_wr ? wr_bytes[k] : 8'hFF);
        if (!cfg_wr) for (int k = 0; k < cfg_len; k++) exp_rd.push_back(flash_bytes[k]);
        exp_under = cfg_wr && (cfg_avail < cfg_len);

        wait_done(name);

        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
        end
        vectors++;
        if (done_busy_bad !== 0) begin
            miscompares++;
            $display("FAIL %s busy_with_done got=%0d exp=0", name, done_busy_bad);
        end
        vectors++;
        if (sent_q.size() !== exp_tx.size()) begin
            miscompares++;
            $display("FAIL %s tx_count got=%0d exp=%0d", name, sent_q.size(), exp_tx.size());
        end
        for (int k = 0; k < exp_tx.size() && k < sent_q.size(); k++) begin
            vectors++;
            if (sent_q[k] !== exp_tx[k]) begin
                miscompares++;
                $display("FAIL %s tx_byte[%0d] got=%02h exp=%02h", name, k, sent_q[k], exp_tx[k]);
            end
        end
        vectors++;
        if (rd_q.size() !== exp_rd.size()) begin
            miscompares++;
            $display("FAIL %s rd_count got=%0d exp=%0d", name, rd_q.size(), exp_rd.size());
        end
        for (int k = 0; k < exp_rd.size() && k < rd_q.size(); k++) begin
            vectors++;
            if (rd_q[k] !== exp_rd[k]) begin
                miscompares++;
                $display("FAIL %s rd_byte[%0d] got=%02h exp=%02h", name, k, rd_q[k], exp_rd[k]);
            end
        end
        vectors++;
        if (underrun !== exp_under) begin
            miscompares++;
            $display("FAIL %s underrun got=%0b exp=%0b", name, underrun, exp_under);
        end
        vectors++;
        if (wr_rdy_cnt !== cfg_avail) begin
            miscompares++;
            $display("FAIL %s wr_ready_pulses got=%0d exp=%0d", name, wr_rdy_cnt, cfg_avail);
        end
        vectors++;
        if (busy !== 1'b0 || m_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_after got busy=%0b m_empty=%0b exp busy=0 m_empty=1", name, busy, m_empty);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if ({m_empty, busy, done, rd_valid, wr_ready, underrun, m_in} !== {6'b100000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state got m_empty=%0b busy=%0b done=%0b rd_valid=%0b wr_ready=%0b underrun=%0b m_in=%02h exp 1,0,0,0,0,0,00",
                     m_empty, busy, done, rd_valid, wr_ready, underrun, m_in);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if (m_empty !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got m_empty=%0b busy=%0b exp 1,0", m_empty, busy);
        end
    endtask

    task automatic test_wren();
        launch(OP_WREN, 32'h0, 3'd0, 4'd0, 0, 1'b0, 0);
        scoreboard_frame("wren");
        vectors++;
        if (sent_q.size() != 1) begin
            miscompares++;
            $display("FAIL wren_single_byte got=%0d exp=1", sent_q.size());
        end
    endtask

    task automatic test_read();
        launch(OP_READ, 32'h0001_2345, 3'd3, 4'd0, 4, 1'b0, 0);
        scoreboard_frame("read");
    endtask

    task automatic test_fast_read();
        launch(OP_FAST_READ, 32'h00AB_CDEF, 3'd3, 4'd1, 2, 1'b0, 0);
        scoreboard_frame("fast_read");
        vectors++;
        if (rd_q.size() != 2) begin
            miscompares++;
            $display("FAIL fast_read_strobes got=%0d exp=2", rd_q.size());
        end
    endtask

    task automatic test_write();
        launch(OP_PP, 32'h00AA_BBCC, 3'd3, 4'd0, 3, 1'b1, 3);
        scoreboard_frame("write");
    endtask

    task automatic test_underrun();
        launch(OP_PP, 32'h0012_3456, 3'd3, 4'd0, 3, 1'b1, 1);
        scoreboard_frame("underrun");
    endtask

    task automatic test_addr_clamp();
        launch(OP_SE, 32'hDEAD_BEEF, 3'd7, 4'd0, 0, 1'b0, 0);
        scoreboard_frame("addr_clamp");
    endtask

    task automatic test_mid_reset();
        int n = 0;
        launch(OP_READ, 32'h0001_2345, 3'd3, 4'd0, 4, 1'b0, 0);
        while (sent_q.size() < 2 && n < 200) begin
            @(negedge clock); #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (m_empty !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_edge got m_empty=%0b busy=%0b exp 1,0", m_empty, busy);
        end
        @(negedge clock); #1;
        reset = 1'b0;
        stray_put = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        vectors++;
        if (done_cnt !== 0 || rd_q.size() !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet got done=%0d rd=%0d exp 0,0", done_cnt, rd_q.size());
        end
        launch(OP_READ, 32'h0001_2345, 3'd3, 4'd0, 4, 1'b0, 0);
        scoreboard_frame("after_reset");
    endtask

    task automatic test_start_busy();
        launch(OP_READ, 32'h0000_5A5A, 3'd2, 4'd0, 6, 1'b0, 0);
        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_during_frame got=%0b exp=1", busy);
        end
        op = OP_SE; addr = 32'hFFFF_FFFF; addr_n = 3'd4; wr = 1'b1;
        start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        scoreboard_frame("start_busy");
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int ln = int'($urandom_range(0, 12));
            bit w = 1'($urandom);
            int av = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : ln;
            launch(8'($urandom), $urandom, 3'($urandom), 4'($urandom), ln, w, av);
            scoreboard_frame($sformatf("random%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_wren();
        test_read();
        test_fast_read();
        test_write();
        test_underrun();
        test_addr_clamp();
        test_mid_reset();
        test_start_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
